// File: rtl/udp_arb_pkg.sv
// Shared types for udp_tx_arbiter: FSM state and the registered output beat.
// beat_t field widths follow the localparams below; the top's width parameters default to them.
package udp_arb_pkg;

    localparam int unsigned BEAT_DATA_W    = 32;
    localparam int unsigned BEAT_EMPTY_W   = 2;
    localparam int unsigned BEAT_CHANNEL_W = 3;

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    typedef struct packed {
        logic [BEAT_CHANNEL_W-1:0] channel;
        logic [BEAT_DATA_W-1:0]    data;
        logic                      valid;
        logic                      sop;
        logic                      eop;
        logic [BEAT_EMPTY_W-1:0]   empty;
    } beat_t;

endpackage

// File: rtl/udp_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping.
module rr_picker #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [IDX_W-1:0]  pick,
    output logic              any
);

    int unsigned idx;

    // Scan from the farthest offset down so the nearest requester after 'last' wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = 0;
        for (int k = int'(NUM_CH); k >= 1; k--) begin
            idx = (32'(last) + 32'(k)) % NUM_CH;
            if (req[idx[IDX_W-1:0]]) begin
                pick = idx[IDX_W-1:0];
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-atomic round-robin arbiter onto one registered Avalon-ST output stage.
// Optional per-source packet and orphan-drop counters under UDP_ARB_STATS_EN.
module udp_tx_arbiter
    import udp_arb_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned DATA_WIDTH    = BEAT_DATA_W,
    parameter int unsigned EMPTY_WIDTH   = BEAT_EMPTY_W,
    parameter int unsigned CHANNEL_WIDTH = BEAT_CHANNEL_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  avsi_data,
    input  logic [NUM_CH*EMPTY_WIDTH-1:0] avsi_empty,
    input  logic [NUM_CH-1:0]             avsi_valid,
    input  logic [NUM_CH-1:0]             avsi_sop,
    input  logic [NUM_CH-1:0]             avsi_eop,
    output logic [NUM_CH-1:0]             avsi_ready,
    output logic [DATA_WIDTH-1:0]         avso_data,
    output logic [EMPTY_WIDTH-1:0]        avso_empty,
    output logic [CHANNEL_WIDTH-1:0]      avso_channel,
    output logic                          avso_valid,
    output logic                          avso_sop,
    output logic                          avso_eop,
    input  logic                          avso_ready,
    output logic                          busy
`ifdef UDP_ARB_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]          pkt_count,
    output logic [15:0]                   drop_count
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_CH);

    state_e           state_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] last_q;
    beat_t            out_q;
    logic             busy_q;

    logic [NUM_CH-1:0] req;
    logic [IDX_W-1:0]  pick;
    logic              any;
    logic              ready_g;

    assign req     = avsi_valid & avsi_sop;
    assign ready_g = ~out_q.valid | avso_ready;

    rr_picker #(
        .NUM_CH(NUM_CH),
        .IDX_W (IDX_W)
    ) u_picker (
        .req (req),
        .last(last_q),
        .pick(pick),
        .any (any)
    );

    // Idle drains orphan mid-packet beats and holds sop beats for arbitration.
    always_comb begin
        avsi_ready = '0;
        if (state_q == StIdle) begin
            avsi_ready = avsi_valid & ~avsi_sop;
        end else begin
            avsi_ready[grant_q] = ready_g;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_CH - 1);
            out_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // The final eop beat of the last packet may still be waiting downstream.
                    if (avso_ready) begin
                        out_q.valid <= 1'b0;
                    end
                    if (any) begin
                        grant_q <= pick;
                        last_q  <= pick;
                        state_q <= StSend;
                        busy_q  <= 1'b1;
                    end
                end
                StSend: begin
                    if (ready_g) begin
                        out_q.channel <= BEAT_CHANNEL_W'(grant_q);
                        out_q.data    <= BEAT_DATA_W'(avsi_data[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH]);
                        out_q.empty   <= BEAT_EMPTY_W'(
                            avsi_empty[32'(grant_q)*EMPTY_WIDTH +: EMPTY_WIDTH]);
                        out_q.valid   <= avsi_valid[grant_q];
                        out_q.sop     <= avsi_sop[grant_q];
                        out_q.eop     <= avsi_eop[grant_q];
                        if (avsi_valid[grant_q] && avsi_eop[grant_q]) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign avso_data    = DATA_WIDTH'(out_q.data);
    assign avso_empty   = EMPTY_WIDTH'(out_q.empty);
    assign avso_channel = CHANNEL_WIDTH'(out_q.channel);
    assign avso_valid   = out_q.valid;
    assign avso_sop     = out_q.sop;
    assign avso_eop     = out_q.eop;
    assign busy         = busy_q;

`ifdef UDP_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (state_q == StIdle) begin
                drop_count <= drop_count + 16'($countones(avsi_ready));
            end
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (state_q == StSend && grant_q == IDX_W'(i) && ready_g &&
                    avsi_valid[i] && avsi_eop[i]) begin
                    pkt_count[i*16 +: 16] <= pkt_count[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
